// File: rtl/mem_traffic_gen_inorder_if.sv
// Master/slave memory port: req/addr/cmd/wdata towards the slave, ack/rdata/resp back.
// Request fields are held by the master until req && ack; resp returns read data in order.
interface mem_traffic_gen_inorder_if;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        resp;

  modport master (
    output req,
    output addr,
    output cmd,
    output wdata,
    input  ack,
    input  rdata,
    input  resp
  );

  modport slave (
    input  req,
    input  addr,
    input  cmd,
    input  wdata,
    output ack,
    output rdata,
    output resp
  );
endinterface

// File: rtl/mem_traffic_gen_inorder.sv
// In-order write-then-readback sweep master; registered outputs, first req one cycle after start, requests held until acked.
// Reads capped at MAX_OUTSTANDING in flight; MEM_TRAFFIC_GEN_RAND_GAP_EN adds LFSR-driven idle bubbles before new requests.
module mem_traffic_gen_inorder #(
  parameter int unsigned NUM_WORDS       = 256,
  parameter logic [31:0] ADDR_BASE       = 32'h0,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = 32'hC0DE0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  mem_traffic_gen_inorder_if.master  master,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [15:0]                err_cnt_o,
  output logic [31:0]                err_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [4:0]  MAX_OUT  = 5'(MAX_OUTSTANDING);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req;
  logic        w_req_nxt;
  logic [31:0] r_addr;
  logic [31:0] w_addr_nxt;
  logic        r_cmd;
  logic        w_cmd_nxt;
  logic [31:0] r_wdata;
  logic [31:0] w_wdata_nxt;
  logic [15:0] r_idx;
  logic [15:0] w_idx_nxt;
  logic [15:0] w_idx_inc;
  logic [15:0] r_exp_idx;
  logic [4:0]  r_out;
  logic [4:0]  w_out_nxt;
  logic        r_busy;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_err;
  logic [15:0] r_err_cnt;
  logic [31:0] r_err_addr;

  logic        w_xfer;
  logic        w_rd_acc;
  logic        w_resp_ok;
  logic        w_resp_bad;
  logic        w_mismatch;
  logic        w_room;
  logic        w_gap_ok;
  logic        w_start;
  logic        w_busy_nxt;

  function automatic logic [31:0] f_data(input logic [15:0] idx);
    return {~idx, idx} ^ SEED;
  endfunction

  function automatic logic [31:0] f_addr(input logic [15:0] idx);
    return ADDR_BASE + {14'd0, idx, 2'b00};
  endfunction

`ifdef MEM_TRAFFIC_GEN_RAND_GAP_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Only gates raising a new request; a request already on the bus is held regardless.
  assign w_gap_ok = (r_lfsr[1:0] != 2'b00);
`else
  assign w_gap_ok = 1'b1;
`endif

  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_xfer     = r_req && master.ack;
  assign w_rd_acc   = w_xfer && !r_cmd;
  assign w_resp_ok  = master.resp && (r_state == S_READ || r_state == S_DRAIN) && (r_out != 5'd0);
  assign w_resp_bad = master.resp && !w_resp_ok;
  assign w_out_nxt  = r_out + {4'd0, w_rd_acc} - {4'd0, w_resp_ok};
  // Next-cycle occupancy decides the next read, so a freed slot is reused one cycle after its response.
  assign w_room     = (w_out_nxt < MAX_OUT);
  assign w_mismatch = w_resp_ok && (master.rdata != f_data(r_exp_idx));
  assign w_idx_inc  = r_idx + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_cmd_nxt   = r_cmd;
    w_wdata_nxt = r_wdata;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_done;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_WRITE;
          w_done_nxt  = 1'b0;
          w_idx_nxt   = 16'd0;
          w_req_nxt   = w_gap_ok;
          w_addr_nxt  = f_addr(16'd0);
          w_cmd_nxt   = 1'b1;
          w_wdata_nxt = f_data(16'd0);
        end
      end
      S_WRITE: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_READ;
            w_idx_nxt   = 16'd0;
            w_req_nxt   = w_gap_ok && w_room;
            w_addr_nxt  = f_addr(16'd0);
            w_cmd_nxt   = 1'b0;
            w_wdata_nxt = 32'd0;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_req_nxt   = w_gap_ok;
            w_addr_nxt  = f_addr(w_idx_inc);
            w_wdata_nxt = f_data(w_idx_inc);
          end
        end else if (!r_req) begin
          w_req_nxt = w_gap_ok;
        end
      end
      S_READ: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DRAIN;
            w_req_nxt   = 1'b0;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_req_nxt  = w_gap_ok && w_room;
            w_addr_nxt = f_addr(w_idx_inc);
          end
        end else if (!r_req) begin
          w_req_nxt = w_gap_ok && w_room;
        end
      end
      S_DRAIN: begin
        if (w_out_nxt == 5'd0) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ) || (w_state_nxt == S_DRAIN);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= 32'd0;
      r_cmd   <= 1'b0;
      r_wdata <= 32'd0;
      r_idx   <= 16'd0;
      r_out   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_cmd   <= w_cmd_nxt;
      r_wdata <= w_wdata_nxt;
      r_idx   <= w_idx_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Error capture; a new sweep clears everything and restarts the expected index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_exp_idx  <= 16'd0;
      r_err      <= 1'b0;
      r_err_cnt  <= 16'd0;
      r_err_addr <= 32'd0;
    end else if (w_start) begin
      r_exp_idx  <= 16'd0;
      r_err      <= 1'b0;
      r_err_cnt  <= 16'd0;
      r_err_addr <= 32'd0;
    end else begin
      if (w_resp_ok) begin
        r_exp_idx <= r_exp_idx + 16'd1;
      end
      if (w_mismatch || w_resp_bad) begin
        r_err <= 1'b1;
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (!r_err) begin
          r_err_addr <= w_resp_bad ? 32'hFFFFFFFF : f_addr(r_exp_idx);
        end
      end
    end
  end

  assign master.req   = r_req;
  assign master.addr  = r_addr;
  assign master.cmd   = r_cmd;
  assign master.wdata = r_wdata;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign err_cnt_o    = r_err_cnt;
  assign err_addr_o   = r_err_addr;

endmodule

// File: tb/tb_mem_traffic_gen_inorder.sv
// Directed bench: behavioural slave memory plus a queue of expected transfers checked as the DUT issues them.
module tb_mem_traffic_gen_inorder;

  localparam int          NW      = 8;
  localparam logic [31:0] TB_SEED = 32'hC0DE0000;

  typedef struct packed {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
  logic [31:0] err_addr_o;

  mem_traffic_gen_inorder_if bus ();

  mem_traffic_gen_inorder #(
    .NUM_WORDS      (NW),
    .ADDR_BASE      (32'h0),
    .MAX_OUTSTANDING(4),
    .SEED           (TB_SEED)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .master     (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o),
    .err_addr_o (err_addr_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_resp_cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          stall_cnt = 0;
  int          t_done;
  bit          pend_resp = 1'b0;
  bit          spur_arm = 1'b0;
  bit          resp_en = 1'b1;
  bit          flip_en = 1'b0;
  bit          stall_arm = 1'b0;
  bit          stalling = 1'b0;
  logic [31:0] pend_rdata = 32'h0;
  logic [31:0] mem [NW];
  xfer_t       exp_q [$];

  function automatic logic [31:0] exp_data(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {~v, v} ^ TB_SEED;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of slave behaviour, evaluated at the falling edge ahead of the DUT's sampling edge.
  task automatic step();
    xfer_t e;
    @(negedge clk);
    cyc++;
    bus.resp  = pend_resp | spur_arm;
    bus.rdata = pend_resp ? pend_rdata : 32'h0;
    if (pend_resp) last_resp_cyc = cyc;
    pend_resp = 1'b0;
    spur_arm  = 1'b0;

    if (stall_arm && stall_cnt == 0 && bus.req && bus.cmd && bus.addr == 32'h8) stalling = 1'b1;
    if (stalling && stall_cnt < 5) begin
      bus.ack = 1'b0;
      stall_cnt++;
      chk("stall_req", bus.req, 1);
      chk("stall_addr", bus.addr, 32'h8);
      chk("stall_cmd", bus.cmd, 1);
      chk("stall_wdata", bus.wdata, TB_SEED ^ 32'hFFFD0002);
    end else begin
      bus.ack = 1'b1;
    end

    if (!rst_ni) begin
      exp_q.delete();
    end else if (bus.req && bus.ack) begin
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xfer_cmd", bus.cmd, e.cmd);
        chk("xfer_addr", bus.addr, e.addr);
        chk("xfer_wdata", bus.wdata, e.wdata);
      end
      if (bus.cmd) begin
        mem[bus.addr[4:2]] = bus.wdata;
        wr_cnt++;
      end else begin
        rd_cnt++;
        pend_resp  = resp_en;
        pend_rdata = mem[bus.addr[4:2]] ^ ((flip_en && bus.addr == 32'hC) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic start_sweep();
    step();
    start_i = 1'b1;
    wr_cnt  = 0;
    rd_cnt  = 0;
    for (int i = 0; i < NW; i++) exp_q.push_back({1'b1, 32'(4 * i), exp_data(i)});
    for (int i = 0; i < NW; i++) exp_q.push_back({1'b0, 32'(4 * i), 32'h0});
    step();
    start_i = 1'b0;
    chk("start_req", bus.req, 1);
    chk("start_busy", busy_o, 1);
    chk("start_done_clr", done_o, 0);
    chk("start_err_clr", err_o, 0);
    chk("start_errcnt_clr", err_cnt_o, 0);
    chk("start_erraddr_clr", err_addr_o, 0);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (done_o === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk("done_seen", t >= 0, 1);
    if (t >= 0) begin
      chk("done_latency", t, last_resp_cyc + 1);
      chk("done_busy_low", busy_o, 0);
      chk("sweep_writes", wr_cnt, NW);
      chk("sweep_reads", rd_cnt, NW);
      chk("sb_empty", exp_q.size(), 0);
    end
  endtask

  task automatic settle_done();
    for (int k = 0; k < 3; k++) step();
    chk("done_held", done_o, 1);
    chk("idle_req", bus.req, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, bus.req, 0);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_cmd"}, bus.cmd, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_errcnt"}, err_cnt_o, 0);
    chk({tag, "_erraddr"}, err_addr_o, 0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    bus.resp  = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;

    // Power-on reset
    step();
    step();
    chk_reset_outputs("por");
    rst_ni = 1'b1;
    step();

    // Clean sweep
    start_sweep();
    wait_done(t_done);
    chk("clean_err", err_o, 0);
    chk("clean_errcnt", err_cnt_o, 0);
    settle_done();

    // Corrupted readback of word 3
    flip_en = 1'b1;
    start_sweep();
    wait_done(t_done);
    flip_en = 1'b0;
    chk("flip_errcnt", err_cnt_o, 1);
    chk("flip_erraddr", err_addr_o, 32'h0000000C);
    chk("flip_err", err_o, 1);
    chk("flip_done", done_o, 1);
    settle_done();

    // Ack withheld for five cycles on write 2
    stall_arm = 1'b1;
    start_sweep();
    wait_done(t_done);
    stall_arm = 1'b0;
    chk("stall_cycles", stall_cnt, 5);
    chk("stall_errcnt", err_cnt_o, 0);
    settle_done();

    // Spurious response during the write phase
    start_sweep();
    for (int k = 0; k < 50 && wr_cnt < 3; k++) step();
    chk("spur_in_write", busy_o && bus.cmd, 1);
    spur_arm = 1'b1;
    step();
    step();
    chk("spur_errcnt_next", err_cnt_o, 1);
    chk("spur_erraddr_next", err_addr_o, 32'hFFFFFFFF);
    wait_done(t_done);
    chk("spur_errcnt_final", err_cnt_o, 1);
    chk("spur_erraddr_final", err_addr_o, 32'hFFFFFFFF);
    chk("spur_err", err_o, 1);
    settle_done();

    // Slave never responds: reads stop at the outstanding limit
    resp_en = 1'b0;
    start_sweep();
    for (int k = 0; k < 40; k++) step();
    chk("noresp_reads", rd_cnt, 4);
    chk("noresp_req", bus.req, 0);
    chk("noresp_busy", busy_o, 1);
    chk("noresp_done", done_o, 0);
    chk("noresp_sb_left", exp_q.size(), 4);
    rst_ni = 1'b0;
    step();
    chk_reset_outputs("noresp_rst");
    rst_ni  = 1'b1;
    resp_en = 1'b1;
    step();

    // One-cycle reset in the middle of the read phase, then a clean restart
    start_sweep();
    for (int k = 0; k < 50 && rd_cnt < 3; k++) step();
    chk("midrd_reading", rd_cnt, 3);
    rst_ni = 1'b0;
    step();
    chk_reset_outputs("midrd_rst");
    rst_ni = 1'b1;
    step();
    chk("midrd_still_idle", busy_o, 0);
    start_sweep();
    wait_done(t_done);
    chk("restart_errcnt", err_cnt_o, 0);
    chk("restart_err", err_o, 0);
    settle_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
